elevator_scan_ctrl: RTL and testbench

Parametrised elevator car controller for an N-floor shaft. It registers car calls and up/down hall calls through a valid/ready request port and serves them in SCAN order, continuing in the current direction until no requests remain ahead. It times floor-to-floor travel and door dwell, handles door obstruction and reopen, and supports an emergency stop. It feeds the existing floor-display decoder and status LEDs through `current_floor` and the status outputs.

---
 rtl/elevator_scan_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_elevator_scan_ctrl.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl
//   SCAN-order elevator car controller for an N-floor shaft. Car calls and
//   up/down hall calls arrive through a valid/ready request port and are held
//   as per-floor call bits. The car keeps its direction while calls remain
//   ahead, then reverses. Travel, door dwell and door closing are timed by a
//   shared cycle counter. Door obstruction reopens or extends the dwell, and a
//   level-sensitive emergency input halts the car while keeping all calls.
//
// Ports
//   clk, reset         clock; asynchronous active-high reset
//   req_valid/ready    request handshake (ready low only in EMERGENCY)
//   req_floor/type     requested floor; 0 car, 1 hall up, 2 hall down, 3 illegal
//   emergency          level-sensitive stop
//   door_obstruct      door sensor blocked
//   current_floor      car position
//   dir_up             SCAN direction (1 up, 0 down)
//   moving, door_open  status decodes of the state
//   state_o            IDLE=0 MOVE=1 ARRIVE=2 DOOR_OPEN=3 DOOR_CLOSE=4 EMERGENCY=5
//   pending            per-floor OR of all call bits
//   arrive_pulse       high for the single ARRIVE cycle
//   req_err            one-cycle pulse after an illegal request is dropped
module elevator_scan_ctrl #(
    parameter int NUM_FLOORS        = 8,
    parameter int TRAVEL_CYCLES     = 100,
    parameter int DOOR_OPEN_CYCLES  = 100,
    parameter int DOOR_CLOSE_CYCLES = 20,
    localparam int FW = $clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [FW-1:0]         req_floor,
    input  logic [1:0]            req_type,
    input  logic                  emergency,
    input  logic                  door_obstruct,
    output logic [FW-1:0]         current_floor,
    output logic                  dir_up,
    output logic                  moving,
    output logic                  door_open,
    output logic [2:0]            state_o,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  arrive_pulse,
    output logic                  req_err
);
    localparam int MAX_AB  = (TRAVEL_CYCLES > DOOR_OPEN_CYCLES) ? TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
    localparam int MAX_CYC = (MAX_AB > DOOR_CLOSE_CYCLES) ? MAX_AB : DOOR_CLOSE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC) + 1;

    localparam logic [CW-1:0] TRAVEL_LAST = CW'(TRAVEL_CYCLES - 1);
    localparam logic [CW-1:0] OPEN_LAST   = CW'(DOOR_OPEN_CYCLES - 1);
    localparam logic [CW-1:0] CLOSE_LAST  = CW'(DOOR_CLOSE_CYCLES - 1);
    localparam logic [FW:0]   FLOOR_LIMIT = (FW + 1)'(NUM_FLOORS);
    localparam logic [NUM_FLOORS-1:0] BIT0 = {{(NUM_FLOORS - 1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_MOVE       = 3'd1,
        S_ARRIVE     = 3'd2,
        S_DOOR_OPEN  = 3'd3,
        S_DOOR_CLOSE = 3'd4,
        S_EMERGENCY  = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [FW-1:0]         floor_q, floor_d;
    logic                  dir_up_q, dir_up_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [NUM_FLOORS-1:0] car_q, car_d, up_q, up_d, dn_q, dn_d;
    logic                  req_err_q, req_err_d;

    logic [NUM_FLOORS-1:0] pend, req_onehot, here_onehot;
    logic                  above, below, ahead, behind, at_here, stop_here;
    logic                  accept, illegal, legal_acc, same_floor, discard;
    logic                  clr_car, clr_up, clr_dn;
    int unsigned           floor_idx;

    // Call bookkeeping and SCAN look-ahead
    always_comb begin
        pend        = car_q | up_q | dn_q;
        floor_idx   = 32'(floor_q);
        above       = 1'b0;
        below       = 1'b0;
        for (int unsigned i = 0; i < NUM_FLOORS; i++) begin
            if (i > floor_idx) above = above | pend[i];
            if (i < floor_idx) below = below | pend[i];
        end
        ahead       = dir_up_q ? above : below;
        behind      = dir_up_q ? below : above;
        at_here     = pend[floor_q];
        // A hall call against the travel direction only stops the car when it
        // is the last thing left in this direction.
        stop_here   = car_q[floor_q]
                    | (dir_up_q ? up_q[floor_q] : dn_q[floor_q])
                    | ((dir_up_q ? dn_q[floor_q] : up_q[floor_q]) & ~ahead);

        accept      = req_valid & req_ready;
        illegal     = ({1'b0, req_floor} >= FLOOR_LIMIT) | (req_type == 2'd3);
        legal_acc   = accept & ~illegal;
        same_floor  = legal_acc & (req_floor == floor_q);
        // Same-floor calls are already being served when the door is (about to
        // be) open; during an emergency they are kept since the door shuts.
        discard     = same_floor & ~emergency
                    & ((state_q == S_DOOR_OPEN) | (state_q == S_DOOR_CLOSE)
                       | ((state_q == S_ARRIVE) & stop_here));
        req_onehot  = BIT0 << req_floor;
        here_onehot = BIT0 << floor_q;
    end

    // Next-state, counter and call-bit update
    always_comb begin
        state_d   = state_q;
        floor_d   = floor_q;
        dir_up_d  = dir_up_q;
        cnt_d     = cnt_q;
        clr_car   = 1'b0;
        clr_up    = 1'b0;
        clr_dn    = 1'b0;
        req_err_d = accept & illegal;

        if (emergency) begin
            state_d = S_EMERGENCY;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    cnt_d = '0;
                    if (at_here) begin
                        state_d = S_DOOR_OPEN;
                        clr_car = 1'b1;
                        clr_up  = 1'b1;
                        clr_dn  = 1'b1;
                    end else if (ahead) begin
                        state_d = S_MOVE;
                    end else if (behind) begin
                        dir_up_d = ~dir_up_q;
                        state_d  = S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (cnt_q == TRAVEL_LAST) begin
                        cnt_d   = '0;
                        floor_d = dir_up_q ? floor_q + FW'(1) : floor_q - FW'(1);
                        state_d = S_ARRIVE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_ARRIVE: begin
                    cnt_d = '0;
                    if (stop_here) begin
                        state_d = S_DOOR_OPEN;
                        clr_car = 1'b1;
                        clr_up  = dir_up_q | ~ahead;
                        clr_dn  = ~dir_up_q | ~ahead;
                    end else if (ahead) begin
                        state_d = S_MOVE;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_DOOR_OPEN: begin
                    if (door_obstruct) begin
                        cnt_d = '0;
                    end else if (cnt_q == OPEN_LAST) begin
                        cnt_d   = '0;
                        state_d = S_DOOR_CLOSE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                S_DOOR_CLOSE: begin
                    if (door_obstruct | same_floor) begin
                        cnt_d   = '0;
                        state_d = S_DOOR_OPEN;
                    end else if (cnt_q == CLOSE_LAST) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            endcase
        end

        // Clears are applied before sets so a simultaneous set wins.
        car_d = (car_q & ~(clr_car ? here_onehot : '0))
              | ((legal_acc & ~discard & (req_type == 2'd0)) ? req_onehot : '0);
        up_d  = (up_q & ~(clr_up ? here_onehot : '0))
              | ((legal_acc & ~discard & (req_type == 2'd1)) ? req_onehot : '0);
        dn_d  = (dn_q & ~(clr_dn ? here_onehot : '0))
              | ((legal_acc & ~discard & (req_type == 2'd2)) ? req_onehot : '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            floor_q   <= '0;
            dir_up_q  <= 1'b1;
            cnt_q     <= '0;
            car_q     <= '0;
            up_q      <= '0;
            dn_q      <= '0;
            req_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            floor_q   <= floor_d;
            dir_up_q  <= dir_up_d;
            cnt_q     <= cnt_d;
            car_q     <= car_d;
            up_q      <= up_d;
            dn_q      <= dn_d;
            req_err_q <= req_err_d;
        end
    end

    assign req_ready     = (state_q != S_EMERGENCY);
    assign current_floor = floor_q;
    assign dir_up        = dir_up_q;
    assign moving        = (state_q == S_MOVE);
    assign door_open     = (state_q == S_DOOR_OPEN) | (state_q == S_DOOR_CLOSE);
    assign state_o       = state_q;
    assign pending       = pend;
    assign arrive_pulse  = (state_q == S_ARRIVE);
    assign req_err       = req_err_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Self-checking bench for elevator_scan_ctrl (8 floors, travel 4, open 3,
// close 2), with a 6-floor instance for out-of-range floor numbers.
module tb_elevator_scan_ctrl;
    localparam int NF    = 8;
    localparam int TRAV  = 4;
    localparam int OPEN  = 3;
    localparam int CLOSE = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic [2:0] req_floor = '0;
    logic [1:0] req_type = '0;
    logic       emergency = 1'b0;
    logic       door_obstruct = 1'b0;

    logic          req_ready, dir_up, moving, door_open, arrive_pulse, req_err;
    logic [2:0]    current_floor, state_o;
    logic [NF-1:0] pending;

    logic       ready6, dir6, moving6, door6, arrive6, err6;
    logic [2:0] floor6, state6;
    logic [5:0] pend6;

    elevator_scan_ctrl #(
        .NUM_FLOORS(NF), .TRAVEL_CYCLES(TRAV),
        .DOOR_OPEN_CYCLES(OPEN), .DOOR_CLOSE_CYCLES(CLOSE)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_floor(req_floor), .req_type(req_type), .emergency(emergency),
        .door_obstruct(door_obstruct), .current_floor(current_floor),
        .dir_up(dir_up), .moving(moving), .door_open(door_open),
        .state_o(state_o), .pending(pending), .arrive_pulse(arrive_pulse),
        .req_err(req_err)
    );

    elevator_scan_ctrl #(
        .NUM_FLOORS(6), .TRAVEL_CYCLES(TRAV),
        .DOOR_OPEN_CYCLES(OPEN), .DOOR_CLOSE_CYCLES(CLOSE)
    ) dut6 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready6),
        .req_floor(req_floor), .req_type(req_type), .emergency(emergency),
        .door_obstruct(door_obstruct), .current_floor(floor6),
        .dir_up(dir6), .moving(moving6), .door_open(door6),
        .state_o(state6), .pending(pend6), .arrive_pulse(arrive6),
        .req_err(err6)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input bit v, input int f, input int t);
        req_valid = v;
        req_floor = 3'(f);
        req_type  = 2'(t);
    endtask

    // Leaves the caller at the negedge where reset drops (cycle 0).
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drv(0, 0, 0);
        emergency     = 1'b0;
        door_obstruct = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    // States use the externally visible numbering; timers count down the
    // cycles left in the current phase.
    int m_state, m_floor, m_left;
    bit m_dir, m_err;
    bit m_car[NF], m_up[NF], m_dn[NF];

    function automatic bit calls_beyond(input int fl, input bit upward);
        for (int i = 0; i < NF; i++)
            if ((upward && i > fl) || (!upward && i < fl))
                if (m_car[i] || m_up[i] || m_dn[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [NF-1:0] model_pending();
        logic [NF-1:0] p;
        for (int i = 0; i < NF; i++) p[i] = m_car[i] | m_up[i] | m_dn[i];
        return p;
    endfunction

    task automatic model_reset();
        m_state = 0; m_floor = 0; m_left = 0; m_dir = 1'b1; m_err = 1'b0;
        for (int i = 0; i < NF; i++) begin
            m_car[i] = 1'b0; m_up[i] = 1'b0; m_dn[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit v, input int f, input int t, input bit em, input bit ob);
        bit acc, bad, ahead, behind, here, with_dir, against, stop_here, disc;
        bit c_c, c_u, c_d;
        int fl;
        fl        = m_floor;
        acc       = v && (m_state != 5);
        bad       = (f >= NF) || (t == 3);
        ahead     = calls_beyond(fl, m_dir);
        behind    = calls_beyond(fl, !m_dir);
        here      = m_car[fl] || m_up[fl] || m_dn[fl];
        with_dir  = m_dir ? m_up[fl] : m_dn[fl];
        against   = m_dir ? m_dn[fl] : m_up[fl];
        stop_here = m_car[fl] || with_dir || (against && !ahead);
        disc      = acc && !bad && (f == fl) && !em &&
                    (m_state == 3 || m_state == 4 || (m_state == 2 && stop_here));
        c_c = 0; c_u = 0; c_d = 0;
        if (em) m_state = 5;
        else case (m_state)
            0: if (here) begin
                   m_state = 3; m_left = OPEN; c_c = 1; c_u = 1; c_d = 1;
               end else if (ahead) begin
                   m_state = 1; m_left = TRAV;
               end else if (behind) begin
                   m_dir = !m_dir; m_state = 1; m_left = TRAV;
               end
            1: if (m_left == 1) begin
                   m_floor = m_dir ? fl + 1 : fl - 1; m_state = 2;
               end else m_left--;
            2: if (stop_here) begin
                   m_state = 3; m_left = OPEN; c_c = 1;
                   if (m_dir) c_u = 1; else c_d = 1;
                   if (!ahead) begin c_u = 1; c_d = 1; end
               end else if (ahead) begin
                   m_state = 1; m_left = TRAV;
               end else m_state = 0;
            3: if (ob) m_left = OPEN;
               else if (m_left == 1) begin m_state = 4; m_left = CLOSE; end
               else m_left--;
            4: if (ob || (acc && !bad && f == fl)) begin m_state = 3; m_left = OPEN; end
               else if (m_left == 1) m_state = 0;
               else m_left--;
            default: m_state = 0;
        endcase
        if (c_c) m_car[fl] = 1'b0;
        if (c_u) m_up[fl]  = 1'b0;
        if (c_d) m_dn[fl]  = 1'b0;
        if (acc && !bad && !disc) begin
            if (t == 0) m_car[f] = 1'b1;
            if (t == 1) m_up[f]  = 1'b1;
            if (t == 2) m_dn[f]  = 1'b1;
        end
        m_err = acc && bad;
    endtask

    task automatic compare_model();
        chk("rnd_state",   state_o, m_state);
        chk("rnd_floor",   current_floor, m_floor);
        chk("rnd_dir",     dir_up, m_dir);
        chk("rnd_pending", pending, model_pending());
        chk("rnd_req_err", req_err, m_err);
        chk("rnd_ready",   req_ready, m_state != 5);
        chk("rnd_moving",  moving, m_state == 1);
        chk("rnd_door",    door_open, m_state == 3 || m_state == 4);
        chk("rnd_arrive",  arrive_pulse, m_state == 2);
    endtask

    typedef struct {
        int            fl;
        int            ty;
        logic [NF-1:0] exp_pend8;
        bit            exp_err8;
        logic [5:0]    exp_pend6;
        bit            exp_err6;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int stops[$];
        bit dirs[$];
        logic [2:0] prev_state;
        int em_hold, f, t;
        bit v, ob;

        vecs[0] = '{3, 0, 8'h08, 1'b0, 6'h08, 1'b0};
        vecs[1] = '{5, 1, 8'h20, 1'b0, 6'h20, 1'b0};
        vecs[2] = '{7, 2, 8'h80, 1'b0, 6'h00, 1'b1};
        vecs[3] = '{6, 0, 8'h40, 1'b0, 6'h00, 1'b1};
        vecs[4] = '{2, 3, 8'h00, 1'b1, 6'h00, 1'b1};
        vecs[5] = '{0, 0, 8'h01, 1'b0, 6'h01, 1'b0};

        // Reset state of both instances
        do_reset();
        chk("rst_state", state_o, 0);
        chk("rst_floor", current_floor, 0);
        chk("rst_dir", dir_up, 1);
        chk("rst_pending", pending, 0);
        chk("rst_flags", {req_ready, moving, door_open, arrive_pulse, req_err}, 5'b10000);
        chk("rst6_all", {ready6, dir6, moving6, door6, arrive6, err6, floor6, state6, pend6},
            {6'b110000, 3'd0, 3'd0, 6'd0});

        // Request acceptance table
        foreach (vecs[i]) begin
            do_reset();
            drv(1, vecs[i].fl, vecs[i].ty);
            @(negedge clk);
            req_valid = 1'b0;
            chk($sformatf("tbl%0d_pend8", i), pending, vecs[i].exp_pend8);
            chk($sformatf("tbl%0d_err8", i), req_err, vecs[i].exp_err8);
            chk($sformatf("tbl%0d_pend6", i), pend6, vecs[i].exp_pend6);
            chk($sformatf("tbl%0d_err6", i), err6, vecs[i].exp_err6);
            @(negedge clk);
            chk($sformatf("tbl%0d_errpulse", i), {req_err, err6}, 2'b00);
        end

        // Single car call to floor 3
        do_reset();
        drv(1, 3, 0);
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            chk($sformatf("s1_arrive_c%0d", k), arrive_pulse, (k == 6 || k == 11 || k == 16));
            chk($sformatf("s1_door_c%0d", k), door_open, (k >= 17 && k <= 21));
            if (k == 16) chk("s1_floor", current_floor, 3);
            if (k == 22) begin
                chk("s1_idle", state_o, 0);
                chk("s1_pending", pending, 0);
            end
        end

        // SCAN order: car 6, then hall-up 2 and hall-down 4 during first MOVE
        do_reset();
        drv(1, 6, 0);
        prev_state = 3'd0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (k == 2) drv(1, 2, 1);
            if (k == 3) drv(1, 4, 2);
            if (k == 4) req_valid = 1'b0;
            if (state_o == 3'd3 && prev_state != 3'd3 && prev_state != 3'd4) begin
                stops.push_back(int'(current_floor));
                dirs.push_back(dir_up);
            end
            prev_state = state_o;
            if (stops.size() == 3 && state_o == 3'd0) break;
        end
        chk("scan_nstops", stops.size(), 3);
        if (stops.size() == 3) begin
            chk("scan_stop0", stops[0], 2);
            chk("scan_stop1", stops[1], 6);
            chk("scan_stop2", stops[2], 4);
            chk("scan_dirs", {dirs[0], dirs[1], dirs[2]}, 3'b110);
        end
        chk("scan_pending", pending, 0);

        // Obstruction extends dwell; same-floor call reopens from DOOR_CLOSE
        do_reset();
        drv(1, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (k == 2) begin chk("obs_open", state_o, 3); door_obstruct = 1'b1; end
            if (k == 7) door_obstruct = 1'b0;
            if (k >= 7 && k <= 9) chk($sformatf("obs_dwell_c%0d", k), state_o, 3);
            if (k == 10) begin chk("obs_close", state_o, 4); drv(1, 0, 0); end
            if (k == 11) begin
                req_valid = 1'b0;
                chk("reopen_state", state_o, 3);
                chk("reopen_pending", pending, 0);
            end
            if (k == 13) chk("reopen_dwell", state_o, 3);
            if (k == 14) chk("reopen_close", state_o, 4);
            if (k == 16) chk("reopen_idle", {state_o, pending}, {3'd0, 8'h00});
        end

        // Emergency on the 2nd MOVE cycle out of floor 1
        do_reset();
        drv(1, 3, 0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (k == 8) emergency = 1'b1;
            if (k == 9) begin
                chk("em_state", state_o, 5);
                chk("em_floor", current_floor, 1);
                chk("em_ready", req_ready, 0);
                chk("em_pending", pending, 8'h08);
                chk("em_flags", {moving, door_open}, 2'b00);
                drv(1, 5, 0);
            end
            if (k == 10) begin
                req_valid = 1'b0;
                chk("em_noaccept", pending, 8'h08);
            end
            if (k == 11) emergency = 1'b0;
            if (k == 12) chk("em_recover", state_o, 0);
            if (k >= 13 && k <= 16) chk($sformatf("em_move_c%0d", k), state_o, 1);
            if (k == 16) chk("em_floor_hold", current_floor, 1);
            if (k == 17) chk("em_arrive", {state_o, current_floor}, {3'd2, 3'd2});
        end

        // Asynchronous reset in the middle of a MOVE at floor 5
        do_reset();
        drv(1, 7, 0);
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
        end
        chk("ar_pre", {state_o, current_floor}, {3'd1, 3'd5});
        #2 reset = 1'b1;
        #1;
        chk("ar_state", state_o, 0);
        chk("ar_floor", current_floor, 0);
        chk("ar_pending", pending, 0);
        chk("ar_flags", {req_ready, dir_up, moving, door_open, arrive_pulse, req_err}, 6'b110000);
        @(negedge clk);
        reset = 1'b0;

        // Randomised run against the reference model
        do_reset();
        model_reset();
        em_hold = 0;
        for (int c = 0; c < 3000; c++) begin
            compare_model();
            if (em_hold > 0) em_hold--;
            else if ($urandom_range(0, 99) == 0) em_hold = int'($urandom_range(1, 6));
            ob = ($urandom_range(0, 19) == 0);
            v  = ($urandom_range(0, 2) == 0);
            f  = int'($urandom_range(0, NF - 1));
            t  = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            emergency     = (em_hold > 0);
            door_obstruct = ob;
            drv(v, f, t);
            model_step(v, f, t, em_hold > 0, ob);
            @(negedge clk);
            if (n_errors > 40) break;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
